cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
//  Shares the single cacheline adaptor (and thus DRAM) between the I-cache and D-cache miss ports.
//  Grants one requester at a time and latches its address/line/op into holding registers.
//  Drives the adaptor until resp_i, routes the 256-bit fill and resp back to the owner, then re-arbitrates.
//  Sits between the two L1 caches and cacheline_adaptor.
// PARAMETERS
//  ARB_MODE      1     0 = fixed D-cache priority; 1 = round-robin (owner not granted last wins a tie)
//  TIMEOUT_CYC   1024  cycles in a SERVE state before err_o sets; 0 disables watchdog
// PORTS
//  clk            in   1    clock; one clock domain
//  rst            in   1    synchronous, active-high reset
//  i_read_i       in   1    I-cache line read request; level, held until i_resp_o
//  i_address_i    in   32   I-cache line address; valid while i_read_i
//  i_line_o       out  256  fill data to I-cache; valid when i_resp_o
//  i_resp_o       out  1    one-cycle completion to I-cache
//  d_read_i       in   1    D-cache line read request; held until d_resp_o
//  d_write_i      in   1    D-cache writeback request; held until d_resp_o; never with d_read_i
//  d_address_i    in   32   D-cache line address
//  d_line_i       in   256  D-cache writeback data; valid while d_write_i
//  d_line_o       out  256  fill data to D-cache; valid when d_resp_o
//  d_resp_o       out  1    one-cycle completion to D-cache
//  mem_address_o  out  32   to adaptor address_i; from holding reg
//  mem_line_o     out  256  to adaptor line_i; from holding reg
//  mem_read_o     out  1    to adaptor read_i
//  mem_write_o    out  1    to adaptor write_i
//  mem_line_i     in   256  from adaptor line_o
//  mem_resp_i     in   1    from adaptor resp_o; one-cycle pulse
//  err_o          out  1    sticky watchdog flag
// BEHAVIOUR
//  Reset: state=IDLE, last_owner=I, holding regs=0, all outputs 0, err_o=0, watchdog=0.
//  States: IDLE, SERVE_I, SERVE_D, RELEASE (registered).
//  IDLE: no request -> stay. Requests sampled at the clock edge.
//    Single requester -> SERVE_x.
//    Both requesting: ARB_MODE=0 -> D wins. ARB_MODE=1 -> opposite of last_owner wins.
//    On grant: latch address, line and op; update last_owner.
//  SERVE_x: mem_read_o/mem_write_o = latched op, held high for the whole state; address/line held constant.
//    mem_resp_i=1 -> x_resp_o=1 the same cycle (combinational), x_line_o=mem_line_i; next state RELEASE.
//  x_line_o = mem_line_i at all times; x_resp_o = 0 except the owner in the resp cycle.
//  RELEASE: exactly one cycle, mem_read_o=mem_write_o=0, requests ignored, next state IDLE.
//    Guarantees the adaptor sees its request low while it returns to idle.
//    Guarantees the owner has dropped its request before re-arbitration.
//  Latency: request seen at edge k -> mem_read_o/mem_write_o high in cycle k+1.
//    Resp to re-grant: 2 cycles (RELEASE, IDLE).
//  A request arriving while another owner is served waits, unchanged, until IDLE.
//  Watchdog: counter clears on SERVE entry, increments each SERVE cycle, saturates.
//    Count reaching TIMEOUT_CYC sets err_o. err_o clears only on rst; the transaction keeps waiting.
//  mem_resp_i outside SERVE: ignored, no resp forwarded.
//  rst mid-transaction: abort to reset state next edge; the adaptor is reset in the same cycle by the integrator.
// STRUCTURE
//  arb_pkg: typedef enum arb_state_t {IDLE,SERVE_I,SERVE_D,RELEASE}; typedef enum owner_t {OWN_I,OWN_D};
//    op encodings; ARB_FIXED/ARB_RR constants.
//  Sub-module arb_select: combinational tie-break (requests, last_owner, ARB_MODE) -> grant.
//  Top holds FSM, holding regs and watchdog.
// TESTING
//  Single I read 0x0000_1000, adaptor model returns line 0xAA..: mem_read_o high from next cycle; i_resp_o 1 cycle; i_line_o=0xAA..
//  Single D write 0x0000_2000 with line 0x55..: mem_write_o and mem_line_o=0x55.. held until resp; d_resp_o pulses once.
//  ARB_MODE=1, both request at once, then twice more: grants alternate D,I,D (last_owner reset=I).
//  ARB_MODE=0, D requests continuously and I waits: D served each round; I served only when d_read_i/d_write_i low.
//  Post-resp: mem_read_o low for >=2 cycles before next grant; new owner address appears on mem_address_o.
//  TIMEOUT_CYC=8, adaptor never responds: err_o rises after 8 SERVE cycles and stays; rst -> IDLE, outputs 0, err_o 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the I/D cache-miss arbiter.
package arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_READ,
    OP_WRITE
  } op_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational tie-break between the two miss ports.
module arb_select
  import arb_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output logic   grant_valid,
  output owner_t grant_owner
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_I;
    if (i_req && d_req) begin
      // Round-robin hands a tie to whoever was not granted last.
      if (ARB_MODE == ARB_FIXED) grant_owner = OWN_D;
      else                       grant_owner = other_owner(last_owner);
    end else if (d_req) begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the cacheline adaptor between I-cache and D-cache miss ports.
// One owner at a time; request fields are latched on grant and held until resp.
module cache_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ARB_MODE    = ARB_RR,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read_i,
  input  logic [ADDR_W-1:0] i_address_i,
  output logic [LINE_W-1:0] i_line_o,
  output logic              i_resp_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_address_i,
  input  logic [LINE_W-1:0] d_line_i,
  output logic [LINE_W-1:0] d_line_o,
  output logic              d_resp_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [LINE_W-1:0] mem_line_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_line_i,
  input  logic              mem_resp_i,
  output logic              err_o
);

  localparam bit          WD_EN = (TIMEOUT_CYC != 0);
  localparam int unsigned WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

  arb_state_t        state, state_nxt;
  owner_t            last_owner;
  owner_t            grant_owner;
  op_t               op_q;
  logic              grant_valid;
  logic              grant;
  logic              serving;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;
  logic [WD_W-1:0]   wd_cnt, wd_nxt;
  logic              err_q;

  arb_select #(.ARB_MODE(ARB_MODE)) u_select (
    .i_req       (i_read_i),
    .d_req       (d_read_i | d_write_i),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign serving = (state == SERVE_I) || (state == SERVE_D);
  assign grant   = (state == IDLE) && grant_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:             if (grant_valid) state_nxt = (grant_owner == OWN_D) ? SERVE_D : SERVE_I;
      SERVE_I, SERVE_D: if (mem_resp_i) state_nxt = RELEASE;
      RELEASE:          state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // Watchdog restarts on every grant and saturates at the timeout value.
  always_comb begin
    wd_nxt = wd_cnt;
    if (grant)                                    wd_nxt = '0;
    else if (serving && WD_EN && wd_cnt != WD_MAX) wd_nxt = wd_cnt + WD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWN_I;
      op_q       <= OP_NONE;
      addr_q     <= '0;
      line_q     <= '0;
      wd_cnt     <= '0;
      err_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_nxt;
      if (serving && WD_EN && wd_nxt == WD_MAX) err_q <= 1'b1;
      if (grant) begin
        last_owner <= grant_owner;
        if (grant_owner == OWN_D) begin
          addr_q <= d_address_i;
          line_q <= d_line_i;
          op_q   <= d_write_i ? OP_WRITE : OP_READ;
        end else begin
          addr_q <= i_address_i;
          line_q <= '0;
          op_q   <= OP_READ;
        end
      end
    end
  end

  assign mem_read_o    = serving && (op_q == OP_READ);
  assign mem_write_o   = serving && (op_q == OP_WRITE);
  assign mem_address_o = addr_q;
  assign mem_line_o    = line_q;
  assign i_line_o      = mem_line_i;
  assign d_line_o      = mem_line_i;
  assign i_resp_o      = (state == SERVE_I) && mem_resp_i;
  assign d_resp_o      = (state == SERVE_D) && mem_resp_i;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed table, corner sequences and a randomized run
// against a transaction-level model of grant order and timing.
module tb_cache_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst     [2];
  logic         i_read  [2];
  logic [31:0]  i_addr  [2];
  logic [255:0] i_line  [2];
  logic         i_resp  [2];
  logic         d_read  [2];
  logic         d_write [2];
  logic [31:0]  d_addr  [2];
  logic [255:0] d_wline [2];
  logic [255:0] d_line  [2];
  logic         d_resp  [2];
  logic [31:0]  m_addr  [2];
  logic [255:0] m_wline [2];
  logic         m_read  [2];
  logic         m_write [2];
  logic [255:0] m_rline [2];
  logic         m_resp  [2];
  logic         err     [2];

  int tests = 0;
  int fails = 0;

  // Instance 0: round-robin with a short watchdog; instance 1: fixed D priority.
  cache_arbiter #(.ARB_MODE(1), .TIMEOUT_CYC(8)) dut_rr (
    .clk(clk), .rst(rst[0]),
    .i_read_i(i_read[0]), .i_address_i(i_addr[0]), .i_line_o(i_line[0]), .i_resp_o(i_resp[0]),
    .d_read_i(d_read[0]), .d_write_i(d_write[0]), .d_address_i(d_addr[0]), .d_line_i(d_wline[0]),
    .d_line_o(d_line[0]), .d_resp_o(d_resp[0]),
    .mem_address_o(m_addr[0]), .mem_line_o(m_wline[0]), .mem_read_o(m_read[0]), .mem_write_o(m_write[0]),
    .mem_line_i(m_rline[0]), .mem_resp_i(m_resp[0]), .err_o(err[0])
  );

  cache_arbiter #(.ARB_MODE(0), .TIMEOUT_CYC(1024)) dut_fx (
    .clk(clk), .rst(rst[1]),
    .i_read_i(i_read[1]), .i_address_i(i_addr[1]), .i_line_o(i_line[1]), .i_resp_o(i_resp[1]),
    .d_read_i(d_read[1]), .d_write_i(d_write[1]), .d_address_i(d_addr[1]), .d_line_i(d_wline[1]),
    .d_line_o(d_line[1]), .d_resp_o(d_resp[1]),
    .mem_address_o(m_addr[1]), .mem_line_o(m_wline[1]), .mem_read_o(m_read[1]), .mem_write_o(m_write[1]),
    .mem_line_i(m_rline[1]), .mem_resp_i(m_resp[1]), .err_o(err[1])
  );

  typedef struct {
    int           dut;
    bit           i_rq;
    bit           d_rd;
    bit           d_wr;
    logic [31:0]  i_a;
    logic [31:0]  d_a;
    logic [255:0] d_l;
    logic [255:0] fill;
    bit           first_d;
  } vec_t;

  task automatic chk1(input string n, input logic a, input logic e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0b want %0b", n, a, e);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic chk256(input string n, input logic [255:0] a, input logic [255:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    rst[k] = 1'b1;
    i_read[k] = 1'b0; i_addr[k] = '0;
    d_read[k] = 1'b0; d_write[k] = 1'b0; d_addr[k] = '0; d_wline[k] = '0;
    m_rline[k] = '0; m_resp[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst[k] = 1'b0;
  endtask

  task automatic chk_idle_outputs(input int k, input string n);
    chk1({n, " read"}, m_read[k], 1'b0);
    chk1({n, " write"}, m_write[k], 1'b0);
    chk32({n, " addr"}, m_addr[k], 32'h0);
    chk256({n, " line"}, m_wline[k], '0);
    chk1({n, " err"}, err[k], 1'b0);
  endtask

  // Entered at #1 after the edge that starts the grant; leaves in the RELEASE cycle.
  task automatic serve(input int k, input string tag, input bit own_d, input logic [31:0] addr,
                       input bit wr, input logic [255:0] wline, input int lat, input logic [255:0] fill);
    for (int c = 0; c <= lat; c++) begin
      chk1({tag, " read"}, m_read[k], !wr);
      chk1({tag, " write"}, m_write[k], wr);
      chk32({tag, " addr"}, m_addr[k], addr);
      if (wr) chk256({tag, " wline"}, m_wline[k], wline);
      m_resp[k]  = (c == lat);
      m_rline[k] = (c == lat) ? fill : ~fill;
      @(negedge clk);
      chk1({tag, " i_resp"}, i_resp[k], (c == lat) && !own_d);
      chk1({tag, " d_resp"}, d_resp[k], (c == lat) && own_d);
      if (c == lat) chk256({tag, " fill"}, own_d ? d_line[k] : i_line[k], fill);
      tick();
    end
    m_resp[k] = 1'b0;
    if (own_d) begin
      d_read[k] = 1'b0;
      d_write[k] = 1'b0;
    end else begin
      i_read[k] = 1'b0;
    end
    chk1({tag, " rel read"}, m_read[k], 1'b0);
    chk1({tag, " rel write"}, m_write[k], 1'b0);
  endtask

  // Starts and ends in an IDLE cycle with no requests pending.
  task automatic run_vec(input string tag, input vec_t v);
    int  k;
    bit  second;
    k = v.dut;
    i_read[k] = v.i_rq; i_addr[k] = v.i_a;
    d_read[k] = v.d_rd; d_write[k] = v.d_wr; d_addr[k] = v.d_a; d_wline[k] = v.d_l;
    second = v.first_d ? v.i_rq : (v.d_rd | v.d_wr);
    tick();
    if (v.first_d) serve(k, {tag, " first"}, 1'b1, v.d_a, v.d_wr, v.d_l, 2, v.fill);
    else           serve(k, {tag, " first"}, 1'b0, v.i_a, 1'b0, '0, 2, v.fill);
    tick();
    chk1({tag, " gap read"}, m_read[k], 1'b0);
    chk1({tag, " gap write"}, m_write[k], 1'b0);
    if (second) begin
      tick();
      if (v.first_d) serve(k, {tag, " second"}, 1'b0, v.i_a, 1'b0, '0, 1, ~v.fill);
      else           serve(k, {tag, " second"}, 1'b1, v.d_a, v.d_wr, v.d_l, 1, ~v.fill);
      tick();
    end
  endtask

  task automatic run_random(input int k, input int ncyc);
    bit           rr, ip, dp, dw, drop_i, drop_d, last_d, active, act_d;
    logic [31:0]  ia, da;
    logic [255:0] dl, fill;
    int           last_resp, resp_at;
    rr = (k == 0);
    ip = 0; dp = 0; dw = 0; drop_i = 0; drop_d = 0; last_d = 0; active = 0; act_d = 0;
    ia = '0; da = '0; dl = '0; fill = '0;
    last_resp = -10; resp_at = 0;
    for (int c = 0; c < ncyc; c++) begin
      // ip/dp still hold what was asserted during the previous cycle.
      if (!active && c >= last_resp + 3 && (ip || dp)) begin
        if (ip && dp) act_d = rr ? !last_d : 1'b1;
        else          act_d = dp;
        last_d  = act_d;
        active  = 1'b1;
        resp_at = c + int'($urandom_range(4, 1));
      end
      if (active) begin
        chk1("rnd read", m_read[k], act_d ? !dw : 1'b1);
        chk1("rnd write", m_write[k], act_d && dw);
        chk32("rnd addr", m_addr[k], act_d ? da : ia);
        if (act_d && dw) chk256("rnd wline", m_wline[k], dl);
      end else begin
        chk1("rnd idle read", m_read[k], 1'b0);
        chk1("rnd idle write", m_write[k], 1'b0);
      end
      if (drop_i) ip = 1'b0;
      if (drop_d) dp = 1'b0;
      drop_i = 1'b0;
      drop_d = 1'b0;
      if (!ip && $urandom_range(3, 0) == 0) begin
        ip = 1'b1;
        ia = $urandom & 32'hFFFF_FFE0;
      end
      if (!dp && $urandom_range(3, 0) == 0) begin
        dp = 1'b1;
        dw = 1'($urandom_range(1, 0));
        da = $urandom & 32'hFFFF_FFE0;
        dl = rnd_line();
      end
      i_read[k]  = ip;
      i_addr[k]  = ip ? ia : $urandom;
      d_read[k]  = dp && !dw;
      d_write[k] = dp && dw;
      d_addr[k]  = dp ? da : $urandom;
      d_wline[k] = dp ? dl : rnd_line();
      fill       = rnd_line();
      m_rline[k] = fill;
      m_resp[k]  = active ? (c == resp_at) : ($urandom_range(3, 0) == 0);
      @(negedge clk);
      chk1("rnd i_resp", i_resp[k], active && c == resp_at && !act_d);
      chk1("rnd d_resp", d_resp[k], active && c == resp_at && act_d);
      if (active && c == resp_at) begin
        chk256("rnd fill", act_d ? d_line[k] : i_line[k], fill);
        active    = 1'b0;
        last_resp = c;
        if (act_d) drop_d = 1'b1;
        else       drop_i = 1'b1;
      end
      tick();
    end
    m_resp[k] = 1'b0;
    i_read[k] = 1'b0; d_read[k] = 1'b0; d_write[k] = 1'b0;
    chk1("rnd err", err[k], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t tbl[8];
    // dut 0 rows assume last owner D (left by the D,I,D sequence); dut 1 is fixed priority.
    tbl[0] = '{0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, '0, {32{8'hAA}}, 1'b0};
    tbl[1] = '{0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_2000, {32{8'h55}}, {32{8'h11}}, 1'b1};
    tbl[2] = '{0, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0000_4000, {32{8'h77}}, {32{8'h22}}, 1'b0};
    tbl[3] = '{0, 1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'h0, '0, {32{8'h33}}, 1'b0};
    tbl[4] = '{0, 1'b1, 1'b0, 1'b1, 32'h0000_7000, 32'h0000_8000, {32{8'h0F}}, {32{8'h44}}, 1'b1};
    tbl[5] = '{1, 1'b1, 1'b1, 1'b0, 32'h0000_9000, 32'h0000_A000, '0, {32{8'h66}}, 1'b1};
    tbl[6] = '{1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_B000, '0, {32{8'h88}}, 1'b1};
    tbl[7] = '{1, 1'b1, 1'b0, 1'b1, 32'h0000_C000, 32'h0000_D000, {32{8'hF0}}, {32{8'h99}}, 1'b1};

    for (int k = 0; k < 2; k++) rst[k] = 1'b1;
    fork
      do_reset(0);
      do_reset(1);
    join
    chk_idle_outputs(0, "reset rr");
    chk_idle_outputs(1, "reset fx");

    // Adaptor resp while idle must not be forwarded.
    m_resp[0] = 1'b1;
    m_rline[0] = {32{8'hEE}};
    @(negedge clk);
    chk1("spurious i_resp", i_resp[0], 1'b0);
    chk1("spurious d_resp", d_resp[0], 1'b0);
    tick();
    m_resp[0] = 1'b0;
    chk1("spurious read", m_read[0], 1'b0);

    // Round-robin: both request with last owner I -> D, I, then D again.
    i_read[0] = 1'b1; i_addr[0] = 32'h0000_0100;
    d_read[0] = 1'b1; d_addr[0] = 32'h0000_0200;
    tick();
    serve(0, "rr D1", 1'b1, 32'h0000_0200, 1'b0, '0, 1, {32{8'hA1}});
    d_read[0] = 1'b1; d_addr[0] = 32'h0000_0300;
    tick();
    chk1("rr gap1", m_read[0], 1'b0);
    tick();
    serve(0, "rr I2", 1'b0, 32'h0000_0100, 1'b0, '0, 2, {32{8'hA2}});
    tick();
    chk1("rr gap2", m_read[0], 1'b0);
    tick();
    serve(0, "rr D3", 1'b1, 32'h0000_0300, 1'b0, '0, 1, {32{8'hA3}});
    tick();

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Fixed priority: D keeps re-requesting and I waits until D goes quiet.
    i_read[1] = 1'b1; i_addr[1] = 32'h0000_0E00;
    d_read[1] = 1'b1; d_addr[1] = 32'h0000_D000;
    for (int r = 0; r < 3; r++) begin
      tick();
      serve(1, "fx D", 1'b1, 32'h0000_D000 + 32'(r) * 32'h20, 1'b0, '0, 2, rnd_line());
      if (r < 2) begin
        d_read[1] = 1'b1;
        d_addr[1] = 32'h0000_D000 + 32'(r + 1) * 32'h20;
      end
      tick();
      chk1("fx gap", m_read[1], 1'b0);
    end
    tick();
    serve(1, "fx I", 1'b0, 32'h0000_0E00, 1'b0, '0, 1, rnd_line());
    tick();

    // Watchdog: adaptor never answers; err after 8 serve cycles, cleared only by reset.
    i_read[0] = 1'b1; i_addr[0] = 32'h0000_4000;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk1($sformatf("wd read c%0d", n), m_read[0], 1'b1);
      chk1($sformatf("wd err c%0d", n), err[0], n >= 9);
    end
    rst[0] = 1'b1;
    i_read[0] = 1'b0;
    tick();
    rst[0] = 1'b0;
    chk_idle_outputs(0, "wd reset");
    m_resp[0] = 1'b1;
    @(negedge clk);
    chk1("post reset i_resp", i_resp[0], 1'b0);
    tick();
    m_resp[0] = 1'b0;
    chk1("post reset read", m_read[0], 1'b0);

    do_reset(0);
    run_random(0, 1500);
    do_reset(1);
    run_random(1, 1500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
